// File: rtl/mips_core_pkg.sv
// Shared MIPS core types and sizing constants.
// Used by the memory stage and its result queue.
package mips_core;

   typedef enum logic {
      MEM_READ  = 1'b0,
      MEM_WRITE = 1'b1
   } mem_access_t;

   localparam int MEM_RESULT_DEPTH = 4;

endpackage

// File: rtl/mem_result_queue.sv
// In-order queue of completed memory accesses awaiting writeback/commit.
// Head entry is shown straight from storage; flush drops everything queued.
module mem_result_queue
   import mips_core::*;
#(
   parameter int DEPTH = MEM_RESULT_DEPTH,
   parameter int IDX_W = 6
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       i_valid,
   input  logic                       i_nop,
   input  mem_access_t                i_mem_action,
   input  logic [31:0]                i_data,
   input  logic [IDX_W-1:0]           i_dispatch_index,
   input  logic                       i_flush,
   input  logic                       o_ready,
   output logic                       o_valid,
   output mem_access_t                o_mem_action,
   output logic [31:0]                o_data,
   output logic [IDX_W-1:0]           o_dispatch_index,
   output logic                       o_full,
   output logic [$clog2(DEPTH):0]     o_count,
   output logic                       o_overflow
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   typedef struct packed {
      mem_access_t      mem_action;
      logic [31:0]      data;
      logic [IDX_W-1:0] dispatch_index;
   } entry_t;

   entry_t        mem [DEPTH];
   entry_t        head;
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic [CW-1:0] count;
   logic          overflow;
   logic          full;
   logic          push;
   logic          pop;
   logic          wr_en;

   assign full    = (count == CW'(DEPTH));
   assign o_valid = (count != '0) && !i_flush;
   assign push    = i_valid && !i_nop && !i_flush;
   assign pop     = o_valid && o_ready && !i_flush;
   // A pop in the same cycle frees the slot a full-queue push needs.
   assign wr_en   = push && (!full || pop);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         overflow <= 1'b0;
      end else if (i_flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (wr_en)
            wr_ptr <= wr_ptr + 1'b1;
         if (pop)
            rd_ptr <= rd_ptr + 1'b1;
         count <= count + CW'(wr_en) - CW'(pop);
         if (push && full && !pop)
            overflow <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en)
         mem[wr_ptr] <= '{
            mem_action:     i_mem_action,
            data:           i_data,
            dispatch_index: i_dispatch_index
         };
   end

   assign head             = mem[rd_ptr];
   assign o_mem_action     = head.mem_action;
   assign o_data           = head.data;
   assign o_dispatch_index = head.dispatch_index;
   assign o_full           = full;
   assign o_count          = count;
   assign o_overflow       = overflow;

endmodule
